// File: rtl/demux1x4_tdm.sv
// demux1x4_tdm: time-division demultiplexer, one serial stream to four lanes.
// Slots 0..2 of a frame are staged in a shadow register. All four lanes are
// published together when slot 3 arrives, so y0..y3 always hold one coherent
// frame. A sync strobe aligns the frame. After the first sync the slot counter
// keeps running frame after frame without needing another sync.
module demux1x4_tdm #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             frame_valid,
   output logic             frame_err,
   output logic             locked,
   output logic [3:0]       slot_oh
);

   logic [1:0]       slot_q, slot_d;
   logic             locked_q, locked_d;
   logic [WIDTH-1:0] sh0_q, sh0_d;
   logic [WIDTH-1:0] sh1_q, sh1_d;
   logic [WIDTH-1:0] sh2_q, sh2_d;
   logic [WIDTH-1:0] y0_q, y0_d;
   logic [WIDTH-1:0] y1_q, y1_d;
   logic [WIDTH-1:0] y2_q, y2_d;
   logic [WIDTH-1:0] y3_q, y3_d;
   logic             fv_q, fv_d;
   logic             fe_q, fe_d;

   // Consume one slot per enabled edge; the pulses default low so they last one cycle
   always_comb begin
      slot_d   = slot_q;
      locked_d = locked_q;
      sh0_d    = sh0_q;
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      y0_d     = y0_q;
      y1_d     = y1_q;
      y2_d     = y2_q;
      y3_d     = y3_q;
      fv_d     = 1'b0;
      fe_d     = 1'b0;
      if (en) begin
         if (sync) begin
            // A sync away from slot 0 drops the partial frame and restarts alignment
            if (locked_q && (slot_q != 2'd0)) begin
               fe_d = 1'b1;
            end
            sh0_d    = din;
            slot_d   = 2'd1;
            locked_d = 1'b1;
         end else if (locked_q) begin
            case (slot_q)
               2'd0: begin
                  sh0_d  = din;
                  slot_d = 2'd1;
               end
               2'd1: begin
                  sh1_d  = din;
                  slot_d = 2'd2;
               end
               2'd2: begin
                  sh2_d  = din;
                  slot_d = 2'd3;
               end
               default: begin
                  y0_d   = sh0_q;
                  y1_d   = sh1_q;
                  y2_d   = sh2_q;
                  y3_d   = din;
                  slot_d = 2'd0;
                  fv_d   = 1'b1;
               end
            endcase
         end
      end
   end

   // State registers; reset clears data as well so a broken frame never leaks out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= 2'd0;
         locked_q <= 1'b0;
         sh0_q    <= '0;
         sh1_q    <= '0;
         sh2_q    <= '0;
         y0_q     <= '0;
         y1_q     <= '0;
         y2_q     <= '0;
         y3_q     <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         locked_q <= locked_d;
         sh0_q    <= sh0_d;
         sh1_q    <= sh1_d;
         sh2_q    <= sh2_d;
         y0_q     <= y0_d;
         y1_q     <= y1_d;
         y2_q     <= y2_d;
         y3_q     <= y3_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
      end
   end

   // Next-slot pointer, decoded only from registered state and blank while unlocked
   always_comb begin
      slot_oh = 4'b0000;
      if (locked_q) begin
         slot_oh = 4'b0001 << slot_q;
      end
   end

   assign y0          = y0_q;
   assign y1          = y1_q;
   assign y2          = y2_q;
   assign y3          = y3_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// tb_demux1x4_tdm: scenario tasks plus a randomized run, checked against a
// frame-level model. The model collects the samples of the current frame in a
// queue and publishes them when four samples have been gathered.
module tb_demux1x4_tdm;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       sync;
   logic [3:0] din;
   logic [3:0] y0, y1, y2, y3;
   logic       frame_valid, frame_err, locked;
   logic [3:0] slot_oh;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Frame-level reference model
   logic [3:0] m_frame[$];
   logic [3:0] m_y[4];
   logic       m_locked;
   logic       m_fv;
   logic       m_fe;

   demux1x4_tdm #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .locked(locked), .slot_oh(slot_oh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] obs_vec();
      return {y0, y1, y2, y3, frame_valid, frame_err, locked, slot_oh};
   endfunction

   function automatic logic [22:0] exp_vec();
      logic [3:0] oh;
      oh = m_locked ? (4'b0001 << m_frame.size()) : 4'b0000;
      return {m_y[0], m_y[1], m_y[2], m_y[3], m_fv, m_fe, m_locked, oh};
   endfunction

   task automatic model_reset();
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_y[i] = 4'h0;
      m_locked = 1'b0;
      m_fv = 1'b0;
      m_fe = 1'b0;
   endtask

   task automatic model_sample(input logic e, input logic s, input logic [3:0] d);
      m_fv = 1'b0;
      m_fe = 1'b0;
      if (e) begin
         if (s) begin
            if (m_locked && m_frame.size() != 0) m_fe = 1'b1;
            m_frame.delete();
            m_frame.push_back(d);
            m_locked = 1'b1;
         end else if (m_locked) begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
               for (int i = 0; i < 4; i++) m_y[i] = m_frame[i];
               m_fv = 1'b1;
               m_frame.delete();
            end
         end
      end
   endtask

   // Drive one cycle; returns at posedge+1 with outputs settled
   task automatic drive(input logic e, input logic s, input logic [3:0] d);
      en = e;
      sync = s;
      din = d;
      @(posedge clk);
      model_sample(e, s, d);
      #1;
   endtask

   // Pulse reset between edges (called at posedge+1)
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if (obs_vec() !== 23'd0) $display("FAIL reset_hold: got %h want %h", obs_vec(), 23'd0);
      else pass_cnt++;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'h0);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [3:0] seq[4] = '{4'd1, 4'd0, 4'd1, 4'd1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, (i == 0), seq[i]);
         total_cnt++;
         if (obs_vec() !== exp_vec()) $display("FAIL basic_step%0d: got %h want %h", i, obs_vec(), exp_vec());
         else pass_cnt++;
      end
      total_cnt++;
      if ({y0, y1, y2, y3, frame_valid, locked} !== {4'd1, 4'd0, 4'd1, 4'd1, 1'b1, 1'b1})
         $display("FAIL basic_frame: got y=%h%h%h%h fv=%b lk=%b want y=1011 fv=1 lk=1", y0, y1, y2, y3, frame_valid, locked);
      else pass_cnt++;
      drive(1'b0, 1'b0, 4'h0);
      total_cnt++;
      if (frame_valid !== 1'b0) $display("FAIL basic_fv_pulse: got %b want 0", frame_valid);
      else pass_cnt++;
   endtask

   task automatic test_unlocked();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, (i % 2 == 0) ? 4'hF : 4'h0);
         total_cnt++;
         if (obs_vec() !== 23'd0) $display("FAIL unlocked_step%0d: got %h want %h", i, obs_vec(), 23'd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_resync();
      logic [15:0] y_prev;
      logic [3:0]  tail[3] = '{4'd1, 4'd1, 4'd0};
      do_reset();
      drive(1'b1, 1'b1, 4'd1);
      drive(1'b1, 1'b0, 4'd1);
      drive(1'b1, 1'b0, 4'd1);
      drive(1'b1, 1'b0, 4'd1);
      drive(1'b1, 1'b0, 4'd1);
      drive(1'b1, 1'b0, 4'd1);
      y_prev = {y0, y1, y2, y3};
      drive(1'b1, 1'b1, 4'd0);
      total_cnt++;
      if ({frame_err, frame_valid, slot_oh, y0, y1, y2, y3} !== {1'b1, 1'b0, 4'b0010, y_prev})
         $display("FAIL resync_err: got fe=%b fv=%b oh=%b y=%h want fe=1 fv=0 oh=0010 y=%h", frame_err, frame_valid, slot_oh, {y0, y1, y2, y3}, y_prev);
      else pass_cnt++;
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL resync_model: got %h want %h", obs_vec(), exp_vec());
      else pass_cnt++;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, tail[i]);
      total_cnt++;
      if ({y0, y1, y2, y3, frame_valid, frame_err} !== {4'd0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0})
         $display("FAIL resync_frame: got y=%h fv=%b fe=%b want y=0110 fv=1 fe=0", {y0, y1, y2, y3}, frame_valid, frame_err);
      else pass_cnt++;
   endtask

   task automatic test_gap();
      do_reset();
      drive(1'b1, 1'b1, 4'hA);
      drive(1'b1, 1'b0, 4'h5);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 4'h3);
         total_cnt++;
         if ({slot_oh, frame_valid, frame_err} !== {4'b0100, 1'b0, 1'b0})
            $display("FAIL gap_hold%0d: got oh=%b fv=%b fe=%b want oh=0100 fv=0 fe=0", i, slot_oh, frame_valid, frame_err);
         else pass_cnt++;
      end
      drive(1'b1, 1'b0, 4'hF);
      total_cnt++;
      if (frame_valid !== 1'b0) $display("FAIL gap_early_fv: got %b want 0", frame_valid);
      else pass_cnt++;
      drive(1'b1, 1'b0, 4'h0);
      total_cnt++;
      if ({y0, y1, y2, y3, frame_valid} !== {4'hA, 4'h5, 4'hF, 4'h0, 1'b1})
         $display("FAIL gap_frame: got y=%h fv=%b want y=a5f0 fv=1", {y0, y1, y2, y3}, frame_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] d;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         d = 4'($urandom_range(0, 15));
         drive(1'b1, (i == 0), d);
         total_cnt++;
         if (obs_vec() !== exp_vec() || frame_valid !== (i == 3 || i == 7) || frame_err !== 1'b0)
            $display("FAIL b2b_step%0d: got %h want %h", i, obs_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 1'b1, 4'h1);
      drive(1'b1, 1'b0, 4'h2);
      drive(1'b1, 1'b0, 4'h3);
      drive(1'b1, 1'b0, 4'h4);
      drive(1'b1, 1'b0, 4'h5);
      drive(1'b1, 1'b0, 4'h6);
      drive(1'b1, 1'b0, 4'h7);
      rst_n = 1'b0;
      model_reset();
      #2;
      total_cnt++;
      if (obs_vec() !== 23'd0) $display("FAIL midreset_async: got %h want %h", obs_vec(), 23'd0);
      else pass_cnt++;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 4'h9);
         total_cnt++;
         if (obs_vec() !== 23'd0) $display("FAIL midreset_nosync%0d: got %h want %h", i, obs_vec(), 23'd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic e, s;
      logic [3:0] d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            #1;
         end
         e = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 9) == 0);
         d = 4'($urandom_range(0, 15));
         drive(e, s, d);
         total_cnt++;
         if (obs_vec() !== exp_vec() || (frame_valid && frame_err))
            $display("FAIL random_step%0d: got %h want %h", i, obs_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      sync = 1'b0;
      din = 4'h0;
      model_reset();
      test_reset();
      test_basic();
      test_unlocked();
      test_resync();
      test_gap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
